// File: rtl/conv_window_sched.sv
// conv_window_sched: walks all valid FxF windows of an IMG_H x IMG_W map, sequencing one MAC unit per window.
// Optional pass cycle counter on perf_cycles when CONV_SCHED_PERF_EN is defined; otherwise perf_cycles is 0.
module conv_window_sched #(
   parameter int DATA_WIDTH = 16,
   parameter int D          = 1,
   parameter int F          = 5,
   parameter int IMG_W      = 32,
   parameter int IMG_H      = 32,
   parameter int PE_LAT     = 2,
   localparam int RW        = IMG_H > 1 ? $clog2(IMG_H) : 1,
   localparam int CW        = IMG_W > 1 ? $clog2(IMG_W) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pe_reset,
   output logic [RW-1:0]         win_row,
   output logic [CW-1:0]         win_col,
   input  logic [DATA_WIDTH-1:0] conv_result,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           perf_cycles
);
   localparam int OUT_W = IMG_W - F + 1;
   localparam int OUT_H = IMG_H - F + 1;
   localparam int ACC   = D * F * F + PE_LAT;
   localparam int AW    = $clog2(ACC + 1);
   typedef enum logic [2:0] {IDLE, LOAD, ACCUM, EMIT, FIN} state_t;
   state_t state, next;
   logic [AW-1:0] cnt;
   logic last_cnt, row_end, last_win, accept, advance;
   assign last_cnt = cnt == AW'(ACC - 1);
   assign row_end  = win_col == CW'(OUT_W - 1);
   assign last_win = row_end && win_row == RW'(OUT_H - 1);
   assign accept   = state == IDLE && start;
   assign advance  = state == EMIT && out_ready && !last_win;
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= next;
   always_comb
      next = state == IDLE  ? (start ? LOAD : IDLE) :
             state == LOAD  ? ACCUM :
             state == ACCUM ? (last_cnt ? EMIT : ACCUM) :
             state == EMIT  ? (out_ready ? (last_win ? FIN : LOAD) : EMIT) : IDLE;
   always_comb begin
      busy      = state == LOAD || state == ACCUM || state == EMIT;
      done      = state == FIN;
      pe_reset  = !(state == ACCUM || state == EMIT);
      out_valid = state == EMIT;
   end
   always_ff @(posedge clk)
      if (reset) begin
         cnt      <= '0;
         win_row  <= '0;
         win_col  <= '0;
         out_data <= '0;
      end else begin
         cnt <= (state == ACCUM && !last_cnt) ? cnt + 1'b1 : '0;
         if (accept) begin
            win_row <= '0;
            win_col <= '0;
         end else if (advance) begin
            win_col <= row_end ? '0 : win_col + 1'b1;
            win_row <= row_end ? win_row + 1'b1 : win_row;
         end
         if (state == ACCUM && last_cnt) out_data <= conv_result;
      end
`ifdef CONV_SCHED_PERF_EN
   logic [31:0] perf;
   always_ff @(posedge clk)
      if (reset) perf <= '0;
      else if (accept) perf <= '0;
      else if (busy && !(&perf)) perf <= perf + 1'b1;
   assign perf_cycles = perf;
`else
   assign perf_cycles = '0;
`endif
endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequencing controller for one convolution unit, which multiplies and accumulates one operand pair per clock.
- Walks an IMG_H x IMG_W input map in row-major order over all valid F x F window positions, with stride 1 and no padding.
- For each window it pulses the unit's reset, waits out the accumulation, captures the result, and presents it on a valid/ready output.
- Sits between the feature-map buffer (selected via win_row/win_col) and the downstream pooling/activation stage.

Parameters:
- DATA_WIDTH, 16, result word width (float16).
- D, 1, filter depth.
- F, 5, filter edge size.
- IMG_W, 32, input map width; must be >= F.
- IMG_H, 32, input map height; must be >= F.
- PE_LAT, 2, extra cycles after the last operand before the unit's result is valid.

Ports:
- clk, in, 1, clock; all logic is on posedge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle request to begin a full map pass.
- busy, out, 1, high from the cycle after start is accepted until done.
- done, out, 1, one-cycle pulse after the last window is emitted.
- pe_reset, out, 1, drives the conv unit reset input.
- win_row, out, $clog2(IMG_H), top row of the current window.
- win_col, out, $clog2(IMG_W), left column of the current window.
- conv_result, in, DATA_WIDTH, result from the conv unit.
- out_data, out, DATA_WIDTH, registered window result.
- out_valid, out, 1, out_data is valid.
- out_ready, in, 1, downstream accepts out_data.
- perf_cycles, out, 32, pass cycle count (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk): state=IDLE, busy=0, done=0, pe_reset=1, win_row=0, win_col=0, out_data=0, out_valid=0. Reset mid-pass aborts immediately; no partial output or done is produced.
- Derived constants: OUT_W=IMG_W-F+1, OUT_H=IMG_H-F+1, ACC=D*F*F+PE_LAT.
- State machine:
  - IDLE: pe_reset=1. When start=1, go to LOAD with win_row=win_col=0 and busy=1.
  - LOAD (1 cycle): pe_reset=1; window coordinates are stable. Next state is ACCUM.
  - ACCUM (exactly ACC cycles): pe_reset=0; an internal counter runs 0..ACC-1. On count ACC-1, register conv_result into out_data, then go to EMIT.
  - EMIT: out_valid=1 and out_data is held stable.
    - If out_ready=1 on a cycle, the transfer completes that cycle and out_valid drops next cycle.
    - If that was the last window (win_row=OUT_H-1 and win_col=OUT_W-1), go to FIN.
    - Otherwise advance the coordinates and go to LOAD: win_col+1, or wrap win_col to 0 and increment win_row when win_col=OUT_W-1.
    - If out_ready=0, stay in EMIT; pe_reset stays 0 and the unit idles feeding zeros.
  - FIN (1 cycle): done=1, busy=0, pe_reset=1. Next state is IDLE.
- start is ignored in every state except IDLE, including a start asserted in the same cycle as done.
- win_row/win_col change only on the EMIT to LOAD transition; they are held in all other states.
- Timing with out_ready held at 1: 1+ACC+1 cycles per window. Start accepted at cycle 0 gives LOAD at cycle 1.
- Degenerate map (IMG_W=F, IMG_H=F): exactly one window, then FIN.

Optional Feature:
- Macro: CONV_SCHED_PERF_EN.
- When defined: a 32-bit counter clears on start acceptance and increments every cycle busy=1. It freezes during FIN, saturates at all-ones, and is reset to 0. perf_cycles outputs the counter.
- When undefined: no counter logic is generated and perf_cycles is tied to 0.

Test Plan:
- Normal pass (IMG_W=IMG_H=7, F=5, D=1, PE_LAT=2, out_ready=1): start at cycle 0.
  - Required: 9 outputs with coordinates (0,0),(0,1),(0,2),(1,0)...(2,2).
  - out_valid at cycles 29+29k; done pulse at cycle 262.
  - pe_reset high at cycles 1+29k.
- Backpressure: hold out_ready=0 for 10 cycles on the 4th window.
  - Required: out_data and win_row/win_col stable, no coordinate advance.
  - done delayed by exactly 10 cycles to cycle 272.
- Data capture: conv_result driven to 16'h3C00 only on the final ACCUM cycle of window 0 and 16'h0000 otherwise.
  - Required: out_data=16'h3C00 during window 0 EMIT.
- Reset mid-pass: assert reset during ACCUM of window 2.
  - Required next cycle: IDLE, busy=0, out_valid=0, pe_reset=1, coordinates 0, and no done.
- Start ignore: pulse start while busy and in the done cycle.
  - Required: no restart and no coordinate change.
  - A start pulse one cycle later begins a new pass at (0,0).
- Perf counter (CONV_SCHED_PERF_EN defined, first scenario): perf_cycles=261 after done. With the macro undefined, perf_cycles=0.
